// File: rtl/sub_arb_pkg.sv
// Shared types and helpers for the subtractor-sharing arbiter.
//   state_e : FSM encoding (StIdle = no result held, StBusy = result held)
//   clog2   : ceiling log2, used to size the requester index
package sub_arb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    // Never returns less than 1 so a 1-requester index still has a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first set request bit found
// searching from rr_ptr upward, wrapping modulo NUM_REQ.
//   req     : request vector
//   rr_ptr  : starting search index (always < NUM_REQ)
//   gnt_vec : one-hot winner (all zero when no request)
//   index   : binary index of the winner
//   any     : at least one request present
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] gnt_vec,
    output logic [IDW-1:0]     index,
    output logic               any
);

    always_comb begin
        int  j;
        logic found;
        gnt_vec = '0;
        index   = '0;
        found   = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            j = int'(rr_ptr) + i;
            if (j >= int'(NUM_REQ)) begin
                j = j - int'(NUM_REQ);
            end
            if (!found && req[j]) begin
                found      = 1'b1;
                gnt_vec[j] = 1'b1;
                index      = IDW'(j);
            end
        end
        any = found;
    end

endmodule

// File: rtl/sub_share_arbiter.sv
// Shares one DATAWIDTH-bit subtractor (diff = a - b) among NUM_REQ requesters
// with round-robin grant and a single registered valid/ready result port.
// Optional build macro SUB_ARB_SAT_EN: clamp diff_out to 0 on borrow
// (undefined: wrap modulo 2^DATAWIDTH). borrow is reported either way.
// Ports:
//   Clk, Rst_n : clock, async active-low reset
//   req        : per-requester request, held until granted
//   a_in, b_in : packed operands, requester k at [k*DATAWIDTH +: DATAWIDTH]
//   gnt        : one-hot combinational grant, asserted in the accept cycle only
//   diff_out   : registered difference
//   diff_id    : requester owning diff_out
//   borrow     : a < b (unsigned) for this result
//   diff_valid : result valid
//   rsp_ready  : consumer takes the result this cycle
module sub_share_arbiter
    import sub_arb_pkg::*;
#(
    parameter  int unsigned DATAWIDTH = 8,
    parameter  int unsigned NUM_REQ   = 4,
    localparam int unsigned IDW       = clog2(NUM_REQ)
) (
    input  logic                           Clk,
    input  logic                           Rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   a_in,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   b_in,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [DATAWIDTH-1:0]           diff_out,
    output logic [IDW-1:0]                 diff_id,
    output logic                           borrow,
    output logic                           diff_valid,
    input  logic                           rsp_ready
);

    state_e                 state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [DATAWIDTH-1:0]   diff_q, diff_d;
    logic [IDW-1:0]         id_q, id_d;
    logic                   borrow_q, borrow_d;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [IDW-1:0]         pick_idx;
    logic                   pick_any;
    logic                   accept;
    logic [DATAWIDTH-1:0]   a_sel, b_sel;
    logic [DATAWIDTH:0]     sub_full;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt_vec (pick_gnt),
        .index   (pick_idx),
        .any     (pick_any)
    );

    // Rst_n gating keeps gnt low while reset is held, even with requests present.
    assign accept = pick_any && Rst_n && ((state_q == StIdle) || rsp_ready);
    assign gnt    = accept ? pick_gnt : '0;

    assign a_sel    = a_in[pick_idx*DATAWIDTH +: DATAWIDTH];
    assign b_sel    = b_in[pick_idx*DATAWIDTH +: DATAWIDTH];
    // Extra MSB of the widened subtract is the borrow.
    assign sub_full = {1'b0, a_sel} - {1'b0, b_sel};

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        diff_d   = diff_q;
        id_d     = id_q;
        borrow_d = borrow_q;
        if (accept) begin
            state_d  = StBusy;
            id_d     = pick_idx;
            borrow_d = sub_full[DATAWIDTH];
`ifdef SUB_ARB_SAT_EN
            diff_d   = sub_full[DATAWIDTH] ? '0 : sub_full[DATAWIDTH-1:0];
`else
            diff_d   = sub_full[DATAWIDTH-1:0];
`endif
            rr_ptr_d = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : IDW'(pick_idx + 1'b1);
        end else if ((state_q == StBusy) && rsp_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            diff_q   <= '0;
            id_q     <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            diff_q   <= diff_d;
            id_q     <= id_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff_out   = diff_q;
    assign diff_id    = id_q;
    assign borrow     = borrow_q;
    assign diff_valid = (state_q == StBusy);

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Self-checking bench for sub_share_arbiter (DATAWIDTH=8, NUM_REQ=4).
module tb_sub_share_arbiter;

    logic        Clk;
    logic        Rst_n;
    logic [3:0]  req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic [7:0]  diff_out;
    logic [1:0]  diff_id;
    logic        borrow;
    logic        diff_valid;
    logic        rsp_ready;

    sub_share_arbiter #(
        .DATAWIDTH (8),
        .NUM_REQ   (4)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .gnt        (gnt),
        .diff_out   (diff_out),
        .diff_id    (diff_id),
        .borrow     (borrow),
        .diff_valid (diff_valid),
        .rsp_ready  (rsp_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        logic        rdy;
        logic [3:0]  gnt;
        logic [7:0]  diff;
        logic [1:0]  id;
        logic        brw;
        logic        valid;
    } vec_t;

    typedef struct packed {
        logic [7:0] diff;
        logic [1:0] id;
        logic       brw;
    } res_t;

    // Requester k operands: 0: 5-9, 1: 20-7, 2: 30-31, 3: 40-1
    localparam logic [31:0] AS = {8'd40, 8'd30, 8'd20, 8'd5};
    localparam logic [31:0] BS = {8'd1,  8'd31, 8'd7,  8'd9};
    localparam logic [31:0] A0 = 32'd200;
    localparam logic [31:0] B0 = 32'd55;

    vec_t tbl[15];
    res_t sbq[$];
    res_t held;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [7:0] sat_adj(input logic [7:0] d, input logic b);
`ifdef SUB_ARB_SAT_EN
        return b ? 8'd0 : d;
`else
        return d;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compare DUT result outputs to the scoreboard head (or to the held result).
    task automatic check_result(input string tag, input logic popped);
        res_t e;
        if (popped) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s: scoreboard empty", tag);
                return;
            end
            e    = sbq.pop_front();
            held = e;
        end else begin
            e = held;
        end
        check({tag, " diff"},   32'(diff_out), 32'(sat_adj(e.diff, e.brw)));
        check({tag, " id"},     32'(diff_id),  32'(e.id));
        check({tag, " borrow"}, 32'(borrow),   32'(e.brw));
    endtask

    task automatic apply_row(input int i);
        string tag;
        logic  pushed;
        tag       = $sformatf("row%0d", i);
        req       = tbl[i].req;
        a_in      = tbl[i].a;
        b_in      = tbl[i].b;
        rsp_ready = tbl[i].rdy;
        @(negedge Clk);
        check({tag, " gnt"}, 32'(gnt), 32'(tbl[i].gnt));
        pushed = (tbl[i].gnt != 4'b0000);
        if (pushed) sbq.push_back('{diff: tbl[i].diff, id: tbl[i].id, brw: tbl[i].brw});
        @(posedge Clk);
        #1;
        check({tag, " valid"}, 32'(diff_valid), 32'(tbl[i].valid));
        if (tbl[i].valid) check_result(tag, pushed);
    endtask

    initial begin
        logic [7:0] rr_diff[4];
        logic       rr_brw[4];
        rr_diff = '{8'd252, 8'd13, 8'd255, 8'd39};
        rr_brw  = '{1'b1, 1'b0, 1'b1, 1'b0};

        //            req      a   b   rdy  gnt      diff     id     brw   valid
        tbl[0]  = '{4'b0001, A0, B0, 1'b1, 4'b0001, 8'd145, 2'd0, 1'b0, 1'b1};
        tbl[1]  = '{4'b0000, A0, B0, 1'b1, 4'b0000, 8'd0,   2'd0, 1'b0, 1'b0};
        tbl[2]  = '{4'b1111, AS, BS, 1'b1, 4'b0010, 8'd13,  2'd1, 1'b0, 1'b1};
        tbl[3]  = '{4'b1111, AS, BS, 1'b1, 4'b0100, 8'd255, 2'd2, 1'b1, 1'b1};
        tbl[4]  = '{4'b1111, AS, BS, 1'b1, 4'b1000, 8'd39,  2'd3, 1'b0, 1'b1};
        tbl[5]  = '{4'b1111, AS, BS, 1'b1, 4'b0001, 8'd252, 2'd0, 1'b1, 1'b1};
        tbl[6]  = '{4'b0110, AS, BS, 1'b0, 4'b0000, 8'd0,   2'd0, 1'b0, 1'b1};
        tbl[7]  = '{4'b0110, AS, BS, 1'b0, 4'b0000, 8'd0,   2'd0, 1'b0, 1'b1};
        tbl[8]  = '{4'b0110, AS, BS, 1'b0, 4'b0000, 8'd0,   2'd0, 1'b0, 1'b1};
        tbl[9]  = '{4'b0110, AS, BS, 1'b1, 4'b0010, 8'd13,  2'd1, 1'b0, 1'b1};
        tbl[10] = '{4'b0000, AS, BS, 1'b0, 4'b0000, 8'd0,   2'd0, 1'b0, 1'b1};
        tbl[11] = '{4'b0000, AS, BS, 1'b1, 4'b0000, 8'd0,   2'd0, 1'b0, 1'b0};
        tbl[12] = '{4'b0001, AS, BS, 1'b0, 4'b0001, 8'd252, 2'd0, 1'b1, 1'b1};
        tbl[13] = '{4'b1000, AS, BS, 1'b1, 4'b1000, 8'd39,  2'd3, 1'b0, 1'b1};
        tbl[14] = '{4'b0000, AS, BS, 1'b1, 4'b0000, 8'd0,   2'd0, 1'b0, 1'b0};

        // Reset with requests pending: no grant, outputs cleared.
        Rst_n     = 1'b0;
        req       = 4'b1111;
        a_in      = AS;
        b_in      = BS;
        rsp_ready = 1'b1;
        held      = '0;
        #2;
        check("reset gnt",    32'(gnt),        32'd0);
        check("reset valid",  32'(diff_valid), 32'd0);
        check("reset diff",   32'(diff_out),   32'd0);
        check("reset id",     32'(diff_id),    32'd0);
        check("reset borrow", 32'(borrow),     32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        for (int i = 0; i < 15; i++) apply_row(i);

        // Reset while a result is held.
        req       = 4'b1111;
        rsp_ready = 1'b0;
        @(negedge Clk);
        check("pre-rst gnt", 32'(gnt), 32'b0001);
        sbq.push_back('{diff: 8'd252, id: 2'd0, brw: 1'b1});
        @(posedge Clk);
        #1;
        check("pre-rst valid", 32'(diff_valid), 32'd1);
        check_result("pre-rst", 1'b1);
        #1;
        Rst_n = 1'b0;
        #1;
        check("midrst valid", 32'(diff_valid), 32'd0);
        check("midrst diff",  32'(diff_out),   32'd0);
        check("midrst gnt",   32'(gnt),        32'd0);
        @(posedge Clk);
        #1;
        Rst_n     = 1'b1;
        rsp_ready = 1'b1;

        // Round robin from a fresh pointer, one result per cycle.
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            check($sformatf("rr%0d gnt", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            sbq.push_back('{diff: rr_diff[k % 4], id: 2'(k % 4), brw: rr_brw[k % 4]});
            @(posedge Clk);
            #1;
            check($sformatf("rr%0d valid", k), 32'(diff_valid), 32'd1);
            check_result($sformatf("rr%0d", k), 1'b1);
        end

        // Drain back to idle.
        req = 4'b0000;
        @(negedge Clk);
        check("drain gnt", 32'(gnt), 32'd0);
        @(posedge Clk);
        #1;
        check("drain valid", 32'(diff_valid), 32'd0);
        check("sb empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
